// File: rtl/sync_fifo_buffer.sv
// sync_fifo_buffer
// Single-clock circular-buffer FIFO with a registered read port, occupancy
// decodes and sticky protocol-error bits. The storage array has no reset and
// is written from its own clocked process so it can map onto block RAM.
module sync_fifo_buffer #(
   parameter int WIDTH           = 8,
   parameter int DEPTH           = 8,    // power of two, >= 2
   parameter int AF_LEVEL        = 6,
   parameter int AE_LEVEL        = 2,
   // Enables the push-when-full / pop-when-empty protocol assertions.
   // The occupancy-range assertion is always active.
   parameter bit PROTOCOL_ASSERT = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       data_in,
   output logic [WIDTH-1:0]       data_out,
   output logic                   data_valid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = '0;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] CNT_AE    = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    fifo_count_reg;
   logic [CW-1:0]    count_next;
   logic [WIDTH-1:0] data_out_reg;
   logic             data_valid_reg;
   logic             overflow_reg;
   logic             underflow_reg;
   logic             push_ok;
   logic             pop_ok;

   // Status flags are pure decodes of the registered occupancy.
   assign full         = (fifo_count_reg == CNT_DEPTH);
   assign empty        = (fifo_count_reg == CNT_ZERO);
   assign almost_full  = (fifo_count_reg >= CNT_AF);
   assign almost_empty = (fifo_count_reg <= CNT_AE);

   assign fifo_count = fifo_count_reg;
   assign data_out   = data_out_reg;
   assign data_valid = data_valid_reg;
   assign overflow   = overflow_reg;
   assign underflow  = underflow_reg;

   // Accept decisions and next occupancy. A push into a full FIFO is allowed
   // when a pop frees the slot in the same cycle.
   always_comb begin
      push_ok    = push && (!full || pop);
      pop_ok     = pop && !empty;
      count_next = fifo_count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = fifo_count_reg + CNT_ONE;
         2'b01:   count_next = fifo_count_reg - CNT_ONE;
         default: count_next = fifo_count_reg;
      endcase
   end

   // Storage write port; contents survive reset, writes are blocked while it is held.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   // Pointers, occupancy, registered read word, sticky errors and protocol checks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         data_out_reg   <= '0;
         data_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
      end else begin
         fifo_count_reg <= count_next;
         data_valid_reg <= pop_ok;
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         // Read-before-write: on a full push+pop at the same slot the old word is returned.
         if (pop_ok) begin
            data_out_reg <= mem[rd_ptr_reg];
            rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
         end
         if (push && !push_ok) begin
            overflow_reg <= 1'b1;
         end
         if (pop && !pop_ok) begin
            underflow_reg <= 1'b1;
         end

         if (PROTOCOL_ASSERT && push) begin
            a_push_full: assert (!full || pop)
               else $error("%m: push when full at time %0t", $time);
         end
         if (PROTOCOL_ASSERT && pop) begin
            a_pop_empty: assert (!empty)
               else $error("%m: pop when empty at time %0t", $time);
         end
         a_count_range: assert (fifo_count_reg <= CNT_DEPTH)
            else $error("%m: fifo_count out of range at time %0t", $time);
         c_push_pop: cover (push_ok && pop_ok);
      end
   end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// tb_sync_fifo_buffer
// Exercises sync_fifo_buffer with directed and random push/pop traffic and
// compares every observable output against a queue-based reference model.
module tb_sync_fifo_buffer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [3:0]       fifo_count;
   logic             overflow;
   logic             underflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] exp_out;
   logic             exp_valid;
   logic             exp_ovf;
   logic             exp_unf;

   sync_fifo_buffer #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE),
      .PROTOCOL_ASSERT(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
      .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Expected {full, empty, almost_full, almost_empty} from model occupancy.
   function automatic logic [3:0] exp_flags();
      int n;
      n = exp_q.size();
      return {n == DEPTH, n == 0, n >= AF, n <= AE};
   endfunction

   function automatic logic [3:0] exp_count();
      return 4'(exp_q.size());
   endfunction

   task automatic model_reset();
      exp_q.delete();
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
   endtask

   // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
   task automatic apply(input logic p, input logic po, input logic [WIDTH-1:0] d);
      bit p_ok, po_ok;
      @(negedge clk);
      push = p; pop = po; data_in = d;
      p_ok  = p && (exp_q.size() < DEPTH || po);
      po_ok = po && (exp_q.size() > 0);
      exp_valid = po_ok;
      if (po_ok) exp_out = exp_q.pop_front();
      if (p_ok) exp_q.push_back(d);
      if (p && !p_ok) exp_ovf = 1'b1;
      if (po && !po_ok) exp_unf = 1'b1;
      @(posedge clk);
      #1;
      $display("txn t=%0t push=%0b pop=%0b din=%02h -> cnt=%0d dv=%0b dout=%02h ovf=%0b unf=%0b",
               $time, p, po, d, fifo_count, data_valid, data_out, overflow, underflow);
   endtask

   task automatic test_reset();
      reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (fifo_count !== 4'd0) begin
         n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count);
      end
      n_checks++;
      if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
         n_fail++; $display("FAIL reset_flags got %b want 0101", {full, empty, almost_full, almost_empty});
      end
      n_checks++;
      if ({data_valid, data_out, overflow, underflow} !== 11'd0) begin
         n_fail++; $display("FAIL reset_outputs got dv=%0b dout=%02h ovf=%0b unf=%0b want all 0",
                            data_valid, data_out, overflow, underflow);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) begin
         apply(1'b1, 1'b0, 8'(i));
         n_checks++;
         if (fifo_count !== 4'(i)) begin
            n_fail++; $display("FAIL fill_count got %0d want %0d", fifo_count, i);
         end
         n_checks++;
         if (almost_full !== (i >= AF)) begin
            n_fail++; $display("FAIL fill_almost_full count=%0d got %0b want %0b", i, almost_full, i >= AF);
         end
         n_checks++;
         if ({full, empty, almost_full, almost_empty} !== exp_flags()) begin
            n_fail++; $display("FAIL fill_flags got %b want %b", {full, empty, almost_full, almost_empty}, exp_flags());
         end
         n_checks++;
         if (overflow !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL fill_ovf_dv got ovf=%0b dv=%0b want 0 0", overflow, data_valid);
         end
      end
      n_checks++;
      if (full !== 1'b1) begin
         n_fail++; $display("FAIL fill_full got %0b want 1", full);
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= DEPTH; i++) begin
         apply(1'b0, 1'b1, 8'h00);
         n_checks++;
         if (data_valid !== 1'b1 || data_out !== 8'(i)) begin
            n_fail++; $display("FAIL drain_data got dv=%0b dout=%02h want dv=1 dout=%02h", data_valid, data_out, 8'(i));
         end
         n_checks++;
         if (fifo_count !== 4'(DEPTH - i) || almost_empty !== ((DEPTH - i) <= AE)) begin
            n_fail++; $display("FAIL drain_count got cnt=%0d ae=%0b want cnt=%0d ae=%0b",
                               fifo_count, almost_empty, DEPTH - i, (DEPTH - i) <= AE);
         end
      end
      apply(1'b0, 1'b0, 8'h00);
      n_checks++;
      if (data_valid !== 1'b0 || empty !== 1'b1 || data_out !== 8'h08) begin
         n_fail++; $display("FAIL drain_idle got dv=%0b empty=%0b dout=%02h want dv=0 empty=1 dout=08",
                            data_valid, empty, data_out);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= DEPTH; i++) apply(1'b1, 1'b0, 8'(i));
      apply(1'b1, 1'b0, 8'hAA);
      n_checks++;
      if (overflow !== 1'b1 || fifo_count !== 4'd8 || data_valid !== 1'b0) begin
         n_fail++; $display("FAIL ovf_reject got ovf=%0b cnt=%0d dv=%0b want ovf=1 cnt=8 dv=0",
                            overflow, fifo_count, data_valid);
      end
      apply(1'b1, 1'b1, 8'hBB);
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 8'h01 || fifo_count !== 4'd8 || full !== 1'b1) begin
         n_fail++; $display("FAIL ovf_push_pop got dv=%0b dout=%02h cnt=%0d full=%0b want 1 01 8 1",
                            data_valid, data_out, fifo_count, full);
      end
      while (exp_q.size() > 0) begin
         apply(1'b0, 1'b1, 8'h00);
         n_checks++;
         if (data_valid !== exp_valid || data_out !== exp_out) begin
            n_fail++; $display("FAIL ovf_drain got dv=%0b dout=%02h want dv=%0b dout=%02h",
                               data_valid, data_out, exp_valid, exp_out);
         end
      end
      n_checks++;
      if (data_out !== 8'hBB || overflow !== 1'b1) begin
         n_fail++; $display("FAIL ovf_last got dout=%02h ovf=%0b want BB 1", data_out, overflow);
      end
   endtask

   task automatic test_underflow();
      apply(1'b1, 1'b1, 8'h55);
      n_checks++;
      if (underflow !== 1'b1 || data_valid !== 1'b0 || fifo_count !== 4'd1) begin
         n_fail++; $display("FAIL unf_reject got unf=%0b dv=%0b cnt=%0d want 1 0 1",
                            underflow, data_valid, fifo_count);
      end
      apply(1'b0, 1'b1, 8'h00);
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 8'h55 || fifo_count !== 4'd0) begin
         n_fail++; $display("FAIL unf_readback got dv=%0b dout=%02h cnt=%0d want 1 55 0",
                            data_valid, data_out, fifo_count);
      end
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] d;
      d = 8'h10;
      for (int k = 0; k < 20; k++) begin
         apply(1'b1, (k % 2) == 1, d);
         d = d + 8'h01;
         n_checks++;
         if (fifo_count !== exp_count() || fifo_count > 4'd8) begin
            n_fail++; $display("FAIL wrap_count got %0d want %0d", fifo_count, exp_count());
         end
         n_checks++;
         if (data_valid !== exp_valid || data_out !== exp_out) begin
            n_fail++; $display("FAIL wrap_data got dv=%0b dout=%02h want dv=%0b dout=%02h",
                               data_valid, data_out, exp_valid, exp_out);
         end
      end
      while (exp_q.size() > 0) begin
         apply(1'b0, 1'b1, 8'h00);
         n_checks++;
         if (data_valid !== exp_valid || data_out !== exp_out) begin
            n_fail++; $display("FAIL wrap_drain got dv=%0b dout=%02h want dv=%0b dout=%02h",
                               data_valid, data_out, exp_valid, exp_out);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         n_checks++;
         if (fifo_count !== exp_count() ||
             {full, empty, almost_full, almost_empty} !== exp_flags()) begin
            n_fail++; $display("FAIL rand_status got cnt=%0d flags=%b want cnt=%0d flags=%b",
                               fifo_count, {full, empty, almost_full, almost_empty}, exp_count(), exp_flags());
         end
         n_checks++;
         if (data_valid !== exp_valid || data_out !== exp_out ||
             overflow !== exp_ovf || underflow !== exp_unf) begin
            n_fail++; $display("FAIL rand_data got dv=%0b dout=%02h ovf=%0b unf=%0b want %0b %02h %0b %0b",
                               data_valid, data_out, overflow, underflow,
                               exp_valid, exp_out, exp_ovf, exp_unf);
         end
      end
      while (exp_q.size() > 0) apply(1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 8'(8'h60 + i));
      apply(1'b1, 1'b1, 8'h65);
      n_checks++;
      if (fifo_count !== 4'd5 || data_valid !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b1) begin
         n_fail++; $display("FAIL arst_pre got cnt=%0d dv=%0b ovf=%0b unf=%0b want 5 1 1 1",
                            fifo_count, data_valid, overflow, underflow);
      end
      @(negedge clk);
      push = 1'b1; pop = 1'b0; data_in = 8'h99;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (fifo_count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 ||
          underflow !== 1'b0 || data_valid !== 1'b0) begin
         n_fail++; $display("FAIL arst_immediate got cnt=%0d empty=%0b ovf=%0b unf=%0b dv=%0b want 0 1 0 0 0",
                            fifo_count, empty, overflow, underflow, data_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (fifo_count !== 4'd0 || data_out !== 8'h00) begin
         n_fail++; $display("FAIL arst_held got cnt=%0d dout=%02h want 0 00", fifo_count, data_out);
      end
      @(negedge clk);
      reset = 1'b0; push = 1'b0; pop = 1'b0;
      apply(1'b1, 1'b0, 8'h77);
      n_checks++;
      if (fifo_count !== 4'd1 || empty !== 1'b0) begin
         n_fail++; $display("FAIL arst_push got cnt=%0d empty=%0b want 1 0", fifo_count, empty);
      end
      apply(1'b0, 1'b1, 8'h00);
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 8'h77 || fifo_count !== 4'd0) begin
         n_fail++; $display("FAIL arst_readback got dv=%0b dout=%02h cnt=%0d want 1 77 0",
                            data_valid, data_out, fifo_count);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_overflow();
      test_underflow();
      test_wrap();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
